fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WORD_W, default 31, SHALL set the instruction word width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the memory-ack watchdog limit in cycles (used only under REQ-027).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 fetch_start  in  1  SHALL be a one-cycle pulse requesting a fetch sequence.
REQ-006 run  in  1  SHALL be a level selecting continuous (1) or single-step (0) fetching.
REQ-007 stop  in  1  SHALL be a level halt request.
REQ-008 reg_start_value  in  12  SHALL be the current start-register address.
REQ-009 mem_req  out  1, mem_addr  out  12, mem_ack  in  1, mem_rdata  in  WORD_W  SHALL form the memory read port.
REQ-010 instr_valid  out  1, instr_word  out  WORD_W, instr_addr  out  12, instr_taken  in  1  SHALL form the instruction hand-off port.
REQ-011 do_reg_start_inc  out  1  SHALL be the one-cycle increment strobe to the start register.
REQ-012 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, REQ, HOLD, INC.
REQ-014 IDLE: on fetch_start=1 SHALL go to ADDR; otherwise stay.
REQ-015 ADDR: SHALL latch addr_q <= reg_start_value and go to REQ after exactly one cycle.
REQ-016 REQ: mem_req=1, mem_addr=addr_q; SHALL stay until mem_ack=1, then latch instr_word <= mem_rdata, instr_addr <= addr_q, and go to HOLD.
REQ-017 mem_addr SHALL be stable for the entire time mem_req=1.
REQ-018 HOLD: instr_valid=1; instr_word and instr_addr SHALL stay stable until instr_taken=1, then go to INC.
REQ-019 INC: do_reg_start_inc=1 for exactly one cycle; then go to ADDR if run=1 and stop=0, else IDLE.
REQ-020 ADDR is entered one cycle after the INC strobe, so the incremented start-register value SHALL be captured.
REQ-021 fetch_start SHALL be ignored outside IDLE.
REQ-022 stop SHALL NOT abort an outstanding REQ or HOLD; it takes effect only at the INC decision.
REQ-023 mem_ack outside REQ SHALL be ignored.
REQ-024 Address 12'o7777 SHALL need no special handling; wrap-around is owned by the start register.
REQ-025 The minimum cycle per instruction with mem_ack and instr_taken both immediate SHALL be 4 clocks (ADDR, REQ, HOLD, INC).

Reset
REQ-026 reset=1 SHALL force IDLE from any state, including mid-REQ, and clear mem_req, instr_valid, do_reg_start_inc, busy, addr_q, instr_word, instr_addr, and fetch_fault to 0 on the same edge.

Configuration
REQ-027 With macro FETCH_TIMEOUT_EN defined:
- A counter SHALL count cycles spent in REQ.
- If the count reaches TIMEOUT without mem_ack, the FSM SHALL go to IDLE with no INC strobe and set output fetch_fault (sticky).
- fetch_fault SHALL clear only on reset or the next accepted fetch_start.
REQ-028 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely, and fetch_fault SHALL be tied to 0.

Verification
REQ-029 Bench SHALL cover single-step: reg_start_value=12'o0100, run=0, fetch_start pulse, mem_ack one cycle after mem_req, rdata=31'h1234567, instr_taken immediate -> mem_addr=12'o0100, instr_word=31'h1234567, one inc pulse, then IDLE.
REQ-030 Bench SHALL cover continuous run: run=1 from 12'o0007, start-register model incrementing on the strobe -> successive mem_addr values 0007, 0010, 0011, each 4 cycles apart.
REQ-031 Bench SHALL cover back-pressure: instr_taken held low 10 cycles -> instr_valid high and instr_word stable for 10 cycles; no inc strobe until instr_taken.
REQ-032 Bench SHALL cover stop: stop raised during REQ with run=1 -> transaction completes and hands off, one inc pulse, then IDLE with busy=0.
REQ-033 Bench SHALL cover reset mid-REQ: reset asserted with mem_req=1 -> next cycle mem_req=0, busy=0; a late mem_ack is ignored.
REQ-034 Bench SHALL cover timeout (FETCH_TIMEOUT_EN, TIMEOUT=8): mem_ack never asserted -> after 8 REQ cycles fetch_fault=1, IDLE, no inc strobe.

Source files
------------

// File: rtl/fetch_ctrl.sv
//==============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch sequencer. For each instruction it captures
//               the start-register address, issues a memory read, hands the
//               returned word to the consumer, then strobes the start register
//               to advance. Runs once per fetch_start (run=0) or back to back
//               (run=1) until run drops or stop is raised.
//
// Parameters  : WORD_W   - instruction word width
//               TIMEOUT  - memory-ack watchdog limit in REQ cycles
//                          (only with FETCH_TIMEOUT_EN)
//
// Ports       : clk               in   clock, all state on rising edge
//               reset             in   synchronous active-high reset
//               fetch_start       in   one-cycle fetch request (IDLE only)
//               run               in   1 = continuous, 0 = single step
//               stop              in   halt request, honoured at INC
//               reg_start_value   in   [11:0] current start-register address
//               mem_req           out  memory read request
//               mem_addr          out  [11:0] read address, stable during req
//               mem_ack           in   read acknowledge (REQ only)
//               mem_rdata         in   [WORD_W-1:0] read data
//               instr_valid       out  instruction word available
//               instr_word        out  [WORD_W-1:0] fetched word
//               instr_addr        out  [11:0] address the word came from
//               instr_taken       in   consumer accepts the word
//               do_reg_start_inc  out  one-cycle start-register increment
//               busy              out  high whenever not IDLE
//               fetch_fault       out  sticky watchdog fault
//
// Macro       : FETCH_TIMEOUT_EN - enables the REQ watchdog and fetch_fault.
//               Without it REQ waits forever and fetch_fault is tied low.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter int WORD_W  = 31,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              run,
  input  logic              stop,
  input  logic [11:0]       reg_start_value,
  output logic              mem_req,
  output logic [11:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr_word,
  output logic [11:0]       instr_addr,
  input  logic              instr_taken,
  output logic              do_reg_start_inc,
  output logic              busy,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_REQ  = 3'd2,
    S_HOLD = 3'd3,
    S_INC  = 3'd4
  } state_t;

  state_t      r_state;
  logic [11:0] r_addr_q;

  // r_addr_q is only written in ADDR, while mem_req is low, so the address
  // presented to memory cannot move during an outstanding request.
  assign mem_addr = r_addr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
  // Count value seen on the clock edge that ends the TIMEOUT-th REQ cycle.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_to_cnt;
  logic               r_fault;

  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;

  // TIMEOUT only matters with the watchdog built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Single sequential process: state plus all registered outputs.
  // Every output changes on the same edge as the state it belongs to, so
  // mem_req/instr_valid/do_reg_start_inc/busy are exact decodes of the
  // state register without any combinational path from inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_addr_q         <= 12'd0;
      mem_req          <= 1'b0;
      instr_valid      <= 1'b0;
      instr_word       <= '0;
      instr_addr       <= 12'd0;
      do_reg_start_inc <= 1'b0;
      busy             <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt         <= '0;
      r_fault          <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_start) begin
            r_state <= S_ADDR;
            busy    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            // A newly accepted fetch clears the previous fault.
            r_fault <= 1'b0;
`endif
          end
        end

        S_ADDR: begin
          // Sampled one cycle after the INC strobe in continuous mode, so
          // the start register has already advanced.
          r_addr_q <= reg_start_value;
          mem_req  <= 1'b1;
          r_state  <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end

        S_REQ: begin
          if (mem_ack) begin
            instr_word  <= mem_rdata;
            instr_addr  <= r_addr_q;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_to_cnt == c_cnt_last) begin
            // Abandon the fetch: no hand-off and no start-register advance.
            mem_req <= 1'b0;
            busy    <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + c_cnt_w'(1);
          end
`endif
        end

        S_HOLD: begin
          if (instr_taken) begin
            instr_valid      <= 1'b0;
            do_reg_start_inc <= 1'b1;
            r_state          <= S_INC;
          end
        end

        S_INC: begin
          do_reg_start_inc <= 1'b0;
          // stop is only looked at here, so an in-flight fetch always
          // completes and hands off before halting.
          if (run && !stop) begin
            r_state <= S_ADDR;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state          <= S_IDLE;
          mem_req          <= 1'b0;
          instr_valid      <= 1'b0;
          do_reg_start_inc <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
